// File: rtl/bch_chain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bch_chain_sequencer
//  Purpose  : Runs the BCH demo chain (encode -> noise -> error injection ->
//             decode). It latches the per-run stage enables on start, issues
//             a one-cycle start pulse to each enabled stage in order, and waits
//             for that stage's done pulse under a per-stage watchdog.
//  Option   : BCH_SEQ_CYCLE_CNT_EN adds o_run_cycles, a saturating count of
//             busy cycles for the most recent run.
//  Revision : 1.0 - initial release
// ============================================================================
module bch_chain_sequencer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cfg_bch_en,
    input  logic             i_cfg_noise_en,
    input  logic             i_cfg_err_en,
    output logic             o_enc_start,
    input  logic             i_enc_done,
    output logic             o_noise_start,
    input  logic             i_noise_done,
    output logic             o_err_start,
    input  logic             i_err_done,
    output logic             o_dec_start,
    input  logic             i_dec_done,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
`ifdef BCH_SEQ_CYCLE_CNT_EN
    output logic [CNT_W-1:0] o_run_cycles,
`endif
    output logic [2:0]       o_cur_stage
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENC   = 3'd1,
        S_NOISE = 3'd2,
        S_ERR   = 3'd3,
        S_DEC   = 3'd4,
        S_FIN   = 3'd5,
        S_TOUT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    state_t             r_state;
    state_t             w_nxt;
    state_t             w_after;
    logic               r_bch_en;
    logic               r_noise_en;
    logic               r_err_en;
    logic               r_first;
    logic [CNT_W-1:0]   r_wdog;
    logic [CNT_W-1:0]   w_wdog_inc;
    logic               w_stage_done;
    logic               w_expired;
    logic               w_accept;
    logic               r_enc_start;
    logic               r_noise_start;
    logic               r_err_start;
    logic               r_dec_start;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_wdog_inc = r_wdog + 1'b1;
    // The watchdog limit is reached when this cycle's increment hits it.
    assign w_expired  = (w_wdog_inc >= C_TIMEOUT);

    // Select the current stage's done and its successor; done is masked in the start-pulse cycle
    always_comb begin
        w_stage_done = 1'b0;
        w_after      = S_FIN;
        case (r_state)
            S_ENC: begin
                w_stage_done = i_enc_done;
                w_after      = r_noise_en ? S_NOISE : (r_err_en ? S_ERR : S_DEC);
            end
            S_NOISE: begin
                w_stage_done = i_noise_done;
                w_after      = r_err_en ? S_ERR : (r_bch_en ? S_DEC : S_FIN);
            end
            S_ERR: begin
                w_stage_done = i_err_done;
                w_after      = r_bch_en ? S_DEC : S_FIN;
            end
            S_DEC: begin
                w_stage_done = i_dec_done;
                w_after      = S_FIN;
            end
            default: begin
                w_stage_done = 1'b0;
                w_after      = S_FIN;
            end
        endcase
        w_stage_done = w_stage_done && !r_first;
    end

    // Next-state decision; abort overrides everything outside IDLE
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_cfg_bch_en)        w_nxt = S_ENC;
                    else if (i_cfg_noise_en) w_nxt = S_NOISE;
                    else if (i_cfg_err_en)   w_nxt = S_ERR;
                    else                     w_nxt = S_FIN;
                end
            end
            S_ENC, S_NOISE, S_ERR, S_DEC: begin
                if (w_stage_done)   w_nxt = w_after;
                else if (w_expired) w_nxt = S_TOUT;
            end
            default: w_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && i_abort) begin
            w_nxt = S_IDLE;
        end
    end

    // State register plus registered pulses, status flags, latched config and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_first       <= 1'b0;
            r_wdog        <= '0;
            r_bch_en      <= 1'b0;
            r_noise_en    <= 1'b0;
            r_err_en      <= 1'b0;
            r_enc_start   <= 1'b0;
            r_noise_start <= 1'b0;
            r_err_start   <= 1'b0;
            r_dec_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_nxt;
            r_first       <= (w_nxt != r_state);
            r_wdog        <= ((w_nxt != r_state) || (w_nxt == S_IDLE)) ? '0 : w_wdog_inc;
            r_enc_start   <= (w_nxt == S_ENC)   && (r_state != S_ENC);
            r_noise_start <= (w_nxt == S_NOISE) && (r_state != S_NOISE);
            r_err_start   <= (w_nxt == S_ERR)   && (r_state != S_ERR);
            r_dec_start   <= (w_nxt == S_DEC)   && (r_state != S_DEC);
            r_done        <= (w_nxt == S_FIN);
            r_busy        <= (w_nxt != S_IDLE);
            if (w_accept) begin
                r_bch_en   <= i_cfg_bch_en;
                r_noise_en <= i_cfg_noise_en;
                r_err_en   <= i_cfg_err_en;
                r_timeout  <= 1'b0;
            end else if (w_nxt == S_TOUT) begin
                r_timeout  <= 1'b1;
            end
        end
    end

`ifdef BCH_SEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_run_cycles;

    // Saturating busy-cycle counter, cleared when a run is accepted and held in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cycles <= '0;
        end else if (w_accept) begin
            r_run_cycles <= '0;
        end else if (r_busy && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + 1'b1;
        end
    end

    assign o_run_cycles = r_run_cycles;
`endif

    assign o_enc_start   = r_enc_start;
    assign o_noise_start = r_noise_start;
    assign o_err_start   = r_err_start;
    assign o_dec_start   = r_dec_start;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_cur_stage   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bch_chain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bch_chain_sequencer
//  Purpose  : Self-checking bench for bch_chain_sequencer. Stage responders
//             return done k cycles after each start pulse; every run is
//             compared against a timeline predicted from the stage list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bch_chain_sequencer;

    localparam int TO    = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_abort = 1'b0;
    logic        i_cfg_bch_en = 1'b0, i_cfg_noise_en = 1'b0, i_cfg_err_en = 1'b0;
    logic        i_enc_done = 1'b0, i_noise_done = 1'b0, i_err_done = 1'b0, i_dec_done = 1'b0;
    logic        o_enc_start, o_noise_start, o_err_start, o_dec_start;
    logic        o_busy, o_done, o_timeout;
    logic [2:0]  o_cur_stage;
`ifdef BCH_SEQ_CYCLE_CNT_EN
    logic [15:0] o_run_cycles;
`endif

    bch_chain_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_cfg_bch_en(i_cfg_bch_en), .i_cfg_noise_en(i_cfg_noise_en), .i_cfg_err_en(i_cfg_err_en),
        .o_enc_start(o_enc_start), .i_enc_done(i_enc_done),
        .o_noise_start(o_noise_start), .i_noise_done(i_noise_done),
        .o_err_start(o_err_start), .i_err_done(i_err_done),
        .o_dec_start(o_dec_start), .i_dec_done(i_dec_done),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
`ifdef BCH_SEQ_CYCLE_CNT_EN
        .o_run_cycles(o_run_cycles),
`endif
        .o_cur_stage(o_cur_stage)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Shared between main sequence (writer) and responder (reader) only
    int kk [1:4];
    bit stray_dec = 1'b0;

    // Event logs written only by the responder
    int st_q[$], st_t[$], done_t[$], tout_t[$], trace[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stage responders and event monitor, all at the falling edge
    initial begin
        int due [1:4];
        int last;
        last = 0;
        for (int i = 1; i <= 4; i++) due[i] = -1;
        forever begin
            @(negedge clk);
            if (o_cur_stage == 3'd0) for (int i = 1; i <= 4; i++) due[i] = -1;
            if (o_enc_start)   begin st_q.push_back(1); st_t.push_back(cyc); due[1] = cyc + kk[1]; end
            if (o_noise_start) begin st_q.push_back(2); st_t.push_back(cyc); due[2] = cyc + kk[2]; end
            if (o_err_start)   begin st_q.push_back(3); st_t.push_back(cyc); due[3] = cyc + kk[3]; end
            if (o_dec_start)   begin st_q.push_back(4); st_t.push_back(cyc); due[4] = cyc + kk[4]; end
            if (o_done) done_t.push_back(cyc);
            if (o_cur_stage == 3'd6) tout_t.push_back(cyc);
            if (int'(o_cur_stage) != last) begin
                last = int'(o_cur_stage);
                trace.push_back(last);
            end
            i_enc_done   = (cyc == due[1]);
            i_noise_done = (cyc == due[2]);
            i_err_done   = (cyc == due[3]);
            i_dec_done   = (cyc == due[4]) || (stray_dec && o_cur_stage == 3'd1);
        end
    end

    // One run: start, optionally poke start/cfg mid-run, wait for IDLE, compare with predicted timeline
    task automatic run(input string tag, input bit b, input bit n, input bit e,
                       input int k1, input int k2, input int k3, input int k4,
                       input bit mid_start, output int a_cyc);
        int ms, md, mt, t, fin, tout, guard;
        int exp_s[$], exp_t[$], en[$];
        kk[1] = k1; kk[2] = k2; kk[3] = k3; kk[4] = k4;
        @(negedge clk);
        ms = st_q.size(); md = done_t.size(); mt = tout_t.size();
        i_cfg_bch_en = b; i_cfg_noise_en = n; i_cfg_err_en = e;
        i_start = 1'b1;
        a_cyc = cyc;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy_after_start"}, o_busy, 1);
        check({tag, "_timeout_cleared"}, o_timeout, 0);
        if (mid_start) begin
            @(negedge clk);
            i_start = 1'b1;
            i_cfg_bch_en = ~b; i_cfg_noise_en = ~n; i_cfg_err_en = ~e;
            @(negedge clk);
            i_start = 1'b0;
        end
        guard = 0;
        while (o_busy && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_returned_idle"}, (guard < 300), 1);
        @(negedge clk);
        // Predicted timeline from the enabled stage list
        if (b) en.push_back(1);
        if (n) en.push_back(2);
        if (e) en.push_back(3);
        if (b) en.push_back(4);
        t = a_cyc + 1; fin = -1; tout = -1;
        foreach (en[i]) begin
            exp_s.push_back(en[i]);
            exp_t.push_back(t);
            if (kk[en[i]] >= 1 && kk[en[i]] < TO) t = t + kk[en[i]] + 1;
            else begin tout = t + TO; break; end
        end
        if (tout < 0) fin = t;
        check({tag, "_n_starts"}, st_q.size() - ms, exp_s.size());
        foreach (exp_s[i]) begin
            if (ms + i < st_q.size()) begin
                check({tag, "_start_stage"}, st_q[ms + i], exp_s[i]);
                check({tag, "_start_time"}, st_t[ms + i] - a_cyc, exp_t[i] - a_cyc);
            end
        end
        check({tag, "_n_done"}, done_t.size() - md, (fin >= 0) ? 1 : 0);
        if (fin >= 0 && done_t.size() > md) check({tag, "_done_time"}, done_t[md] - a_cyc, fin - a_cyc);
        check({tag, "_n_tout"}, tout_t.size() - mt, (tout >= 0) ? 1 : 0);
        if (tout >= 0 && tout_t.size() > mt) check({tag, "_tout_time"}, tout_t[mt] - a_cyc, tout - a_cyc);
        check({tag, "_timeout_flag"}, o_timeout, (tout >= 0) ? 1 : 0);
        check({tag, "_idle_stage"}, o_cur_stage, 0);
    endtask

    initial begin
        int a, md, mr, ms, guard;
        for (int i = 1; i <= 4; i++) kk[i] = NEVER;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {o_enc_start, o_noise_start, o_err_start, o_dec_start, o_busy, o_done, o_timeout, o_cur_stage}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {o_busy, o_cur_stage}, 0);

        // T1: full chain, each done 3 cycles after start
        run("T1", 1, 1, 1, 3, 3, 3, 3, 0, a);
        if (done_t.size() > 0) check("T1_latency", done_t[done_t.size() - 1] - a, 17);
`ifdef BCH_SEQ_CYCLE_CNT_EN
        check("T1_run_cycles", o_run_cycles, 17);
`endif

        // T2: encode/decode only, stage trace 1,4,5,0
        mr = trace.size();
        run("T2", 1, 0, 0, 2, NEVER, NEVER, 4, 0, a);
        check("T2_trace_len", trace.size() - mr, 4);
        if (trace.size() - mr == 4) begin
            check("T2_trace0", trace[mr], 1);
            check("T2_trace1", trace[mr + 1], 4);
            check("T2_trace2", trace[mr + 2], 5);
            check("T2_trace3", trace[mr + 3], 0);
        end

        // T3: nothing enabled
        run("T3", 0, 0, 0, 1, 1, 1, 1, 0, a);

        // T4: noise never answers
        run("T4", 1, 1, 1, 3, NEVER, 3, 3, 0, a);
        repeat (5) @(negedge clk);
        check("T4_timeout_sticky", o_timeout, 1);

        // Boundaries: done on the last allowed cycle, done in the start cycle, one cycle late
        run("BND_k7", 1, 1, 1, 7, 7, 7, 7, 0, a);
        run("BND_k0", 0, 1, 0, 1, 0, 1, 1, 0, a);
        run("BND_k8", 1, 0, 1, 8, 1, 1, 1, 0, a);

        // T5: abort during ERR
        kk[1] = 2; kk[2] = 2; kk[3] = 2; kk[4] = 2;
        @(negedge clk);
        md = done_t.size(); ms = st_q.size();
        i_cfg_bch_en = 1; i_cfg_noise_en = 1; i_cfg_err_en = 1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (o_cur_stage != 3'd3 && guard < 100) begin @(negedge clk); guard++; end
        check("T5_reached_err", o_cur_stage, 3);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("T5_abort_idle", {o_busy, o_cur_stage}, 0);
        check("T5_abort_timeout_kept", o_timeout, 0);
        repeat (6) @(negedge clk);
        check("T5_no_done", done_t.size() - md, 0);
        check("T5_no_dec_start", st_q.size() - ms, 3);
        run("T5_rerun", 1, 1, 1, 2, 2, 2, 2, 0, a);

        // T6: start while busy with cfg flipped, stray dec_done during ENC
        stray_dec = 1'b1;
        run("T6_ignore", 1, 1, 1, 2, 3, 2, 2, 1, a);
        stray_dec = 1'b0;

        // T6: rst during DEC
        kk[1] = 1; kk[2] = 1; kk[3] = 1; kk[4] = NEVER;
        @(negedge clk);
        i_cfg_bch_en = 1; i_cfg_noise_en = 1; i_cfg_err_en = 1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        guard = 0;
        while (o_cur_stage != 3'd4 && guard < 100) begin @(negedge clk); guard++; end
        check("T6_reached_dec", o_cur_stage, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("T6_rst_outputs",
              {o_enc_start, o_noise_start, o_err_start, o_dec_start, o_busy, o_done, o_timeout, o_cur_stage}, 0);
        @(negedge clk);
        check("T6_still_idle", {o_busy, o_cur_stage}, 0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            int kr [1:4];
            for (int s = 1; s <= 4; s++) begin
                if ($urandom_range(0, 7) == 0) kr[s] = ($urandom_range(0, 1) == 0) ? 0 : TO;
                else kr[s] = int'($urandom_range(1, TO - 1));
            end
            run("RND", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                kr[1], kr[2], kr[3], kr[4], 1'($urandom_range(0, 3) == 0), a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
